// File: rtl/digdug_devbus_if.sv
// Device-side shared CPU bus: address, read/write strobes and data lanes.
// The arbiter/CPU side drives the master modport, this block responds on the slave modport.
interface digdug_devbus_if;
  logic [15:0] dev_ad;
  logic        dev_rd;
  logic        dev_dv;
  logic [7:0]  dev_do;
  logic        dev_wr;
  logic [7:0]  dev_di;

  modport master (output dev_ad, dev_rd, dev_wr, dev_di, input dev_dv, dev_do);
  modport slave  (input dev_ad, dev_rd, dev_wr, dev_di, output dev_dv, dev_do);
endinterface

// File: rtl/digdug_devbus.sv
// Dig Dug device-bus responder: shared work RAM, main control latch, per-CPU
// reset/IRQ/NMI generation and a frame watchdog that force-resets every CPU.
module digdug_devbus #(
  parameter int RAM_AW     = 12,
  parameter int NMI_W      = 32,
  parameter int WDT_FRAMES = 8,
  parameter int WDT_RSTLEN = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  digdug_devbus_if.slave        bus,
  input  logic                  vblk,
  input  logic [8:0]            vpos,
  output logic [2:0]            rsts,
  output logic [2:0]            irqs,
  output logic [2:0]            nmis,
  output logic [7:0]            latch
);

  localparam int NMI_CW = $clog2(NMI_W + 1);
  localparam int WDT_CW = $clog2(WDT_FRAMES + 1);
  localparam int RST_CW = $clog2(WDT_RSTLEN + 1);

  logic [7:0]        ram [2**RAM_AW];
  logic [RAM_AW-1:0] ram_addr;
  logic [2:0]        idx;
  logic              ram_hit, latch_hit, kick;
  logic              latch_wr, vblk_rise, nmi_trig, nmi_off, fire, wdt_rst;
  logic              vblk_q;
  logic [8:0]        vpos_q;
  logic              pend0, pend1;
  logic [NMI_CW-1:0] nmi_cnt;
  logic [WDT_CW-1:0] wdt_cnt;
  logic [RST_CW-1:0] rst_cnt;

  // NOTE: every variable written here gets a value before any condition, so no latch is inferred.
  always_comb begin
    ram_addr  = bus.dev_ad[RAM_AW-1:0];
    idx       = bus.dev_ad[2:0];
    ram_hit   = bus.dev_ad[15] && ((bus.dev_ad[14:0] >> RAM_AW) == 15'd0);
    latch_hit = (bus.dev_ad[15:3] == 13'h0D04);
    kick      = bus.dev_wr && (bus.dev_ad == 16'h6830);
    latch_wr  = bus.dev_wr && latch_hit;
    vblk_rise = vblk && !vblk_q;
    nmi_trig  = (vpos != vpos_q) && ((vpos == 9'd64) || (vpos == 9'd192));
    nmi_off   = latch[2] || (latch_wr && idx == 3'd2 && bus.dev_di[0]);
    fire      = vblk_rise && !kick && (wdt_cnt == WDT_CW'(WDT_FRAMES - 1));
    wdt_rst   = (rst_cnt != '0);
  end

  // NOTE: work RAM has no reset; clearing a memory array would defeat RAM inference.
  always_ff @(posedge clk) begin
    if (bus.dev_wr && ram_hit) ram[ram_addr] <= bus.dev_di;
  end

  // NOTE: edge-detect samples track the inputs even during reset, so they need no reset value.
  always_ff @(posedge clk) begin
    vblk_q <= vblk;
    vpos_q <= vpos;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.dev_dv <= 1'b0;
      bus.dev_do <= 8'h00;
    end else begin
      bus.dev_dv <= bus.dev_rd && (ram_hit || latch_hit);
      if (bus.dev_rd && ram_hit)        bus.dev_do <= ram[ram_addr];
      else if (bus.dev_rd && latch_hit) bus.dev_do <= {7'b0, latch[idx]};
      else                              bus.dev_do <= 8'h00;
    end
  end

  // A watchdog fire overrides any latch write in the same cycle.
  always_ff @(posedge clk) begin
    if (reset || fire)  latch <= 8'h00;
    else if (latch_wr)  latch[idx] <= bus.dev_di[0];
  end

  always_ff @(posedge clk) begin
    if (reset || wdt_rst) begin
      pend0 <= 1'b0;
      pend1 <= 1'b0;
    end else begin
      if (latch_wr && idx == 3'd0 && !bus.dev_di[0]) pend0 <= 1'b0;
      else if (vblk_rise && latch[0])                pend0 <= 1'b1;
      if (latch_wr && idx == 3'd1 && !bus.dev_di[0]) pend1 <= 1'b0;
      else if (vblk_rise && latch[1])                pend1 <= 1'b1;
    end
  end

  // The disable bit also cancels a pulse on the very edge it is written.
  always_ff @(posedge clk) begin
    if (reset || wdt_rst || nmi_off) nmi_cnt <= '0;
    else if (nmi_trig)               nmi_cnt <= NMI_CW'(NMI_W);
    else if (nmi_cnt != '0)          nmi_cnt <= nmi_cnt - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset || kick || fire) wdt_cnt <= '0;
    else if (vblk_rise)        wdt_cnt <= wdt_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)              rst_cnt <= '0;
    else if (fire)          rst_cnt <= RST_CW'(WDT_RSTLEN);
    else if (rst_cnt != '0) rst_cnt <= rst_cnt - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) rsts <= 3'b111;
    else       rsts <= {{2{wdt_rst || !latch[3]}}, wdt_rst};
  end

  assign irqs = {1'b0, pend1, pend0};
  assign nmis = {(nmi_cnt != '0), 2'b00};

endmodule

// File: tb/tb_digdug_devbus.sv
// Directed bench for digdug_devbus: a cycle-level behavioural model is compared
// against every output each cycle, plus literal expectations for key scenarios.
module tb_digdug_devbus;
  localparam int NMI_W = 32;
  localparam int WDT_FRAMES = 8;
  localparam int WDT_RSTLEN = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       vblk;
  logic [8:0] vpos;
  logic [2:0] rsts, irqs, nmis;
  logic [7:0] latch;

  digdug_devbus_if bus_if ();

  digdug_devbus dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if),
    .vblk  (vblk),
    .vpos  (vpos),
    .rsts  (rsts),
    .irqs  (irqs),
    .nmis  (nmis),
    .latch (latch)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_ram [int];
  logic [7:0] m_latch;
  bit         m_pend0, m_pend1;
  int         m_nmi, m_wdt, m_rstc;
  logic       m_vblk_prev;
  logic [8:0] m_vpos_prev;
  logic       e_dv;
  logic [7:0] e_do;
  logic [2:0] e_rsts;
  bit         m_ok = 0;

  function automatic bit is_ram(input logic [15:0] a);
    return (a >= 16'h8000) && (int'(a) < 32'h8000 + (1 << 12));
  endfunction

  function automatic bit is_latch(input logic [15:0] a);
    return (a >= 16'h6820) && (a <= 16'h6827);
  endfunction

  always @(posedge clk) begin : model
    bit         rise, trig, wrst, kick, fire, lw;
    int         li;
    logic [7:0] old_latch;
    rise = vblk && !m_vblk_prev;
    trig = (vpos != m_vpos_prev) && (vpos == 9'd64 || vpos == 9'd192);
    m_vblk_prev = vblk;
    m_vpos_prev = vpos;
    if (reset) begin
      e_dv = 0; e_do = 8'h00; e_rsts = 3'b111;
      m_latch = 8'h00; m_pend0 = 0; m_pend1 = 0;
      m_nmi = 0; m_wdt = 0; m_rstc = 0;
    end else begin
      old_latch = m_latch;
      wrst = (m_rstc > 0);
      lw = bus_if.dev_wr && is_latch(bus_if.dev_ad);
      li = int'(bus_if.dev_ad) - 'h6820;
      e_rsts = {{2{wrst || !old_latch[3]}}, wrst};
      e_dv = 0; e_do = 8'h00;
      if (bus_if.dev_rd && is_ram(bus_if.dev_ad)) begin
        e_dv = 1;
        e_do = m_ram.exists(int'(bus_if.dev_ad)) ? m_ram[int'(bus_if.dev_ad)] : 8'h00;
      end else if (bus_if.dev_rd && is_latch(bus_if.dev_ad)) begin
        e_dv = 1;
        e_do = {7'b0, old_latch[li]};
      end
      if (bus_if.dev_wr && is_ram(bus_if.dev_ad)) m_ram[int'(bus_if.dev_ad)] = bus_if.dev_di;
      // IRQ pend flags: clear-by-write beats a simultaneous vblank set
      if (wrst) begin m_pend0 = 0; m_pend1 = 0; end
      else begin
        if (lw && li == 0 && !bus_if.dev_di[0]) m_pend0 = 0;
        else if (rise && old_latch[0]) m_pend0 = 1;
        if (lw && li == 1 && !bus_if.dev_di[0]) m_pend1 = 0;
        else if (rise && old_latch[1]) m_pend1 = 1;
      end
      if (wrst || old_latch[2] || (lw && li == 2 && bus_if.dev_di[0])) m_nmi = 0;
      else if (trig) m_nmi = NMI_W;
      else if (m_nmi > 0) m_nmi--;
      kick = bus_if.dev_wr && (bus_if.dev_ad == 16'h6830);
      fire = 0;
      if (kick) m_wdt = 0;
      else if (rise) begin
        m_wdt++;
        if (m_wdt == WDT_FRAMES) begin m_wdt = 0; fire = 1; end
      end
      if (fire) m_rstc = WDT_RSTLEN;
      else if (m_rstc > 0) m_rstc--;
      if (lw) m_latch[li] = bus_if.dev_di[0];
      if (fire) m_latch = 8'h00;
    end
    m_ok = 1;
  end

  always @(negedge clk) begin
    if (m_ok) begin
      check("model_dv", bus_if.dev_dv, e_dv);
      check("model_do", bus_if.dev_do, e_do);
      check("model_rsts", rsts, e_rsts);
      check("model_irqs", irqs, {1'b0, m_pend1, m_pend0});
      check("model_nmis", nmis, {(m_nmi > 0), 2'b00});
      check("model_latch", latch, m_latch);
    end
  end

  bit watch_en = 0;
  bit saw_rst = 0;
  always @(negedge clk) if (watch_en && rsts[0]) saw_rst = 1;

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    bus_if.dev_ad = a; bus_if.dev_di = d; bus_if.dev_wr = 1;
    tick(1);
    bus_if.dev_wr = 0;
  endtask

  task automatic rd(input logic [15:0] a);
    bus_if.dev_ad = a; bus_if.dev_rd = 1;
    tick(1);
    bus_if.dev_rd = 0;
  endtask

  task automatic pulse_vblk();
    vblk = 1; tick(1);
    vblk = 0; tick(3);
  endtask

  initial begin
    #500000;
    $display("FAIL sim_timeout");
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1; vblk = 0; vpos = 9'd0;
    bus_if.dev_ad = 16'h0000; bus_if.dev_rd = 0; bus_if.dev_wr = 0; bus_if.dev_di = 8'h00;
    tick(3);
    check("reset_rsts", rsts, 3'b111);
    check("reset_latch", latch, 8'h00);
    check("reset_dv", bus_if.dev_dv, 1'b0);

    reset = 0; tick(1);
    check("release_rsts", rsts, 3'b110);

    // RAM access and decode boundaries
    wr(16'h8123, 8'h5A);
    rd(16'h8123);
    check("ram_rd_dv", bus_if.dev_dv, 1'b1);
    check("ram_rd_do", bus_if.dev_do, 8'h5A);
    rd(16'h4000);
    check("unserved_dv", bus_if.dev_dv, 1'b0);
    check("unserved_do", bus_if.dev_do, 8'h00);
    wr(16'h8FFF, 8'hC3);
    wr(16'h9000, 8'h77);
    rd(16'h8FFF);
    check("ram_top_do", bus_if.dev_do, 8'hC3);
    rd(16'h9000);
    check("above_ram_dv", bus_if.dev_dv, 1'b0);
    bus_if.dev_ad = 16'h8123; bus_if.dev_rd = 1;
    tick(1); check("held_rd_dv1", bus_if.dev_dv, 1'b1);
    tick(1); check("held_rd_dv2", bus_if.dev_dv, 1'b1);
    bus_if.dev_rd = 0;
    tick(1); check("held_rd_dv_end", bus_if.dev_dv, 1'b0);

    // sub-CPU run bit
    wr(16'h6823, 8'h01);
    tick(1); check("run_rsts", rsts, 3'b000);
    rd(16'h6823);
    check("latch_rd_do", bus_if.dev_do, 8'h01);
    wr(16'h6823, 8'h00);
    tick(1); check("halt_rsts", rsts, 3'b110);

    // IRQs
    wr(16'h6830, 8'h00);
    wr(16'h6820, 8'h01);
    vblk = 1; tick(1);
    check("irq0_set", irqs, 3'b001);
    vblk = 0; tick(3);
    check("irq0_hold", irqs, 3'b001);
    wr(16'h6820, 8'h00);
    check("irq0_clear", irqs, 3'b000);
    pulse_vblk();
    check("irq0_disabled", irqs, 3'b000);
    wr(16'h6820, 8'h01);
    bus_if.dev_ad = 16'h6820; bus_if.dev_di = 8'h00; bus_if.dev_wr = 1; vblk = 1;
    tick(1);
    bus_if.dev_wr = 0; vblk = 0;
    check("irq_clear_wins", irqs, 3'b000);
    tick(3);
    wr(16'h6821, 8'h01);
    pulse_vblk();
    check("irq1_set", irqs, 3'b010);
    wr(16'h6821, 8'h00);
    wr(16'h6830, 8'h00);

    // NMI2 pulse width
    vpos = 9'd63; tick(2);
    vpos = 9'd64; tick(1);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      if (nmis[2]) n++;
      tick(1);
    end
    check("nmi_width", n, NMI_W);
    // retrigger reloads
    vpos = 9'd63; tick(1);
    vpos = 9'd64; tick(10);
    vpos = 9'd192; tick(1);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      if (nmis[2]) n++;
      tick(1);
    end
    check("nmi_retrigger", n, NMI_W);
    // disabled
    wr(16'h6822, 8'h01);
    vpos = 9'd63; tick(1);
    vpos = 9'd64;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (nmis[2]) n++;
    end
    check("nmi_disabled", n, 0);
    // disable mid-pulse
    wr(16'h6822, 8'h00);
    vpos = 9'd63; tick(1);
    vpos = 9'd64; tick(6);
    check("nmi_mid_active", nmis, 3'b100);
    wr(16'h6822, 8'h01);
    check("nmi_mid_drop", nmis, 3'b000);
    wr(16'h6822, 8'h00);
    vpos = 9'd0; tick(2);

    // Watchdog fire
    wr(16'h6830, 8'h00);
    wr(16'h6823, 8'h01);
    wr(16'h6825, 8'h01);
    for (int i = 0; i < WDT_FRAMES - 1; i++) pulse_vblk();
    check("wdt_pre_rsts", rsts, 3'b000);
    vblk = 1; tick(1); vblk = 0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (rsts == 3'b111) n++;
      tick(1);
    end
    check("wdt_rst_len", n, WDT_RSTLEN);
    check("wdt_after_rsts", rsts, 3'b110);
    check("wdt_after_latch", latch, 8'h00);

    // Regular kicks keep the watchdog quiet, including kick+edge in one cycle
    wr(16'h6830, 8'h00);
    watch_en = 1;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < WDT_FRAMES - 1; i++) pulse_vblk();
      wr(16'h6830, 8'h00);
    end
    bus_if.dev_ad = 16'h6830; bus_if.dev_wr = 1; vblk = 1;
    tick(1);
    bus_if.dev_wr = 0; vblk = 0;
    tick(3);
    for (int i = 0; i < WDT_FRAMES - 1; i++) pulse_vblk();
    tick(3);
    watch_en = 0;
    check("wdt_kicked_no_rst", saw_rst, 1'b0);
    wr(16'h6830, 8'h00);

    // Reset mid-NMI with IRQs pending
    wr(16'h6823, 8'h01);
    wr(16'h6820, 8'h01);
    wr(16'h6821, 8'h01);
    pulse_vblk();
    vpos = 9'd63; tick(1);
    vpos = 9'd64; tick(3);
    check("pre_reset_irqs", irqs, 3'b011);
    check("pre_reset_nmis", nmis, 3'b100);
    bus_if.dev_ad = 16'h8123; bus_if.dev_rd = 1;
    reset = 1; tick(1);
    bus_if.dev_rd = 0;
    check("mid_reset_rsts", rsts, 3'b111);
    check("mid_reset_irqs", irqs, 3'b000);
    check("mid_reset_nmis", nmis, 3'b000);
    check("mid_reset_latch", latch, 8'h00);
    check("mid_reset_dv", bus_if.dev_dv, 1'b0);
    check("mid_reset_do", bus_if.dev_do, 8'h00);
    tick(2);
    reset = 0; tick(1);
    check("rerelease_rsts", rsts, 3'b110);
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/digdug_devbus.md
Name: digdug_devbus

Overview:
- Device-side responder on the shared arbitrated CPU bus (DEV_*).
- Serves shared work RAM reads and writes, and holds the main-CPU control latch.
- Generates the per-CPU reset, IRQ and NMI lines that feed back into the CPU cores block.
- Runs a frame watchdog that force-resets all CPUs.

Parameters:
- RAM_AW, 12, shared RAM address width; RAM occupies 0x8000..0x8000+2^RAM_AW-1.
- NMI_W, 32, NMI2 pulse width in clocks.
- WDT_FRAMES, 8, VBLK rising edges without a kick before the watchdog fires.
- WDT_RSTLEN, 16, clocks for which the watchdog asserts all resets.

Ports:
- CLK  in  1  bus clock, same clock as DEV_CL.
- RESET  in  1  synchronous, active-high.
- DEV_AD  in  16  bus address.
- DEV_RD  in  1  read strobe.
- DEV_DV  out  1  read data valid.
- DEV_DO  out  8  read data.
- DEV_WR  in  1  write strobe.
- DEV_DI  in  8  write data.
- VBLK  in  1  vertical blank level from video timing.
- VPOS  in  9  current scanline.
- RSTS  out  3  per-CPU reset, bit n = CPUn.
- IRQS  out  3  per-CPU IRQ level.
- NMIS  out  3  per-CPU NMI level.
- LATCH  out  8  main latch bits, exported to video/sound.

Behaviour:
- Clock and reset: one clock, CLK. Reset is synchronous and active-high (RESET).
- Reset values:
  - DEV_DV=0, DEV_DO=0x00, LATCH=0x00.
  - IRQ pending flags=0, NMI counter=0, watchdog counter=0, watchdog reset counter=0.
  - RSTS=3'b111 while RESET is high. On the first clock after release: RSTS=3'b110.
  - IRQS=0, NMIS=0.
- Address decode (one access per cycle, RD and WR never both high):
  - RAM: DEV_AD in 0x8000..RAM top.
  - Latch: 0x6820-0x6827; index = DEV_AD[2:0].
  - Watchdog kick: 0x6830.
  - Anything else is unserved.
- Reads:
  - DEV_RD=1 to RAM in cycle N gives DEV_DV=1 and DEV_DO=RAM[DEV_AD] in cycle N+1, one-cycle latency.
  - Reads of the latch window return {7'b0, LATCH[idx]} with the same latency.
  - Unserved reads give DEV_DV=0 and DEV_DO=0x00.
  - DEV_DV is a single-cycle registered pulse per cycle that RD is high. A read held for 2 cycles gives DV for 2 cycles.
- Writes:
  - DEV_WR=1 to RAM writes DEV_DI at the clock edge.
  - DEV_WR held for consecutive cycles rewrites the same data; this is harmless.
  - A read issued the cycle after a write to the same address returns the new data.
  - A latch write sets LATCH[idx]=DEV_DI[0].
  - A write to 0x6830 (any data) clears the watchdog counter.
- Latch meaning:
  - LATCH[0]: CPU0 IRQ enable.
  - LATCH[1]: CPU1 IRQ enable.
  - LATCH[2]: NMI2 disable, active-high.
  - LATCH[3]: sub-CPU run, 0 holds CPU1 and CPU2 in reset.
  - LATCH[7:4]: passed through only.
- IRQs:
  - A VBLK rising edge (registered previous-sample compare) sets pend0 if LATCH[0]=1 and pend1 if LATCH[1]=1.
  - Writing LATCH[n]=0 clears pendn the same edge; the clear wins over a simultaneous set.
  - IRQS = {1'b0, pend1, pend0}.
- NMI2:
  - When VPOS changes to 64 or 192 and LATCH[2]=0, load the NMI counter with NMI_W.
  - NMIS[2]=1 while the counter is nonzero.
  - LATCH[2]=1 clears the counter immediately.
  - A retrigger while active reloads the counter.
  - NMIS[1:0]=0.
- Watchdog:
  - The counter increments on each VBLK rising edge. A kick and an edge in the same cycle resolve to 0.
  - On reaching WDT_FRAMES: the counter clears, the reset counter loads WDT_RSTLEN, and LATCH is cleared to 0x00.
  - wdt_rst=1 while the reset counter is nonzero.
- Reset outputs:
  - RSTS[0] = RESET | wdt_rst.
  - RSTS[2:1] = {2{RESET | wdt_rst | ~LATCH[3]}}.
  - All are registered, one-cycle delay relative to their causes.
- Sub-CPU reset: while wdt_rst=1, IRQ pend flags and the NMI counter are held at 0.

Test Plan:
- Write 0x5A to 0x8123, then read 0x8123 -> DEV_DV=1 and DEV_DO=0x5A exactly one cycle after RD; read 0x4000 -> DEV_DV=0, DEV_DO=0x00.
- Release RESET -> RSTS=3'b110; write 0x01 to 0x6823 -> RSTS=3'b000 one cycle later; write 0x00 -> RSTS=3'b110.
- Write 0x01 to 0x6820, then pulse VBLK -> IRQS[0]=1 and stays high; write 0x00 to 0x6820 -> IRQS[0]=0. Same VBLK with 0x6820=0 -> IRQS stays 0.
- Step VPOS 63→64 with LATCH[2]=0 -> NMIS[2] high for exactly 32 clocks. Repeat with 0x6822=1 -> no pulse; set it mid-pulse -> NMIS[2] drops next cycle.
- Give 8 VBLK edges with no kick -> RSTS=3'b111 for 16 clocks, then 3'b110 with LATCH=0x00. Kick at 0x6830 every 7 frames -> RSTS never fires.
- Assert RESET mid-NMI and with IRQ pending -> all outputs return to reset values on the next edge.
